// File: rtl/arb_rr_onehot.sv
// -----------------------------------------------------------------------------
// arb_rr_onehot
//   Round-robin arbiter that produces the select for the shared-bus muxes.
//   A grant is held for a whole transaction and is released or handed over
//   only on a clock edge where the consumer pulses done. Every output comes
//   straight from a flop, so the bus drivers never see a multi-hot select.
//
// Ports
//   clk      in   1          system clock, rising edge
//   clr      in   1          asynchronous active-low reset
//   req      in   NUM_REQ    level-sensitive request per requester
//   done     in   1          one-cycle pulse ending the current transaction
//   gnt      out  NUM_REQ    registered one-hot grant, all-zero when idle
//   gnt_idx  out  IDX_WIDTH  binary index of the granted requester, 0 when idle
//   busy     out  1          high while a grant is held
// -----------------------------------------------------------------------------
module arb_rr_onehot #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [IDX_WIDTH-1:0] gnt_idx,
    output logic                 busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   ptr_q,   ptr_d;
    logic [NUM_REQ-1:0]     gnt_q,   gnt_d;
    logic [IDX_WIDTH-1:0]   idx_q,   idx_d;
    logic                   busy_q,  busy_d;

    logic [IDX_WIDTH-1:0]   ptr_after_owner;
    logic [IDX_WIDTH-1:0]   scan_ptr;
    logic                   win_found;
    logic [IDX_WIDTH-1:0]   win_idx;

    // Pointer that places the current owner at lowest priority. Explicit wrap
    // so a NUM_REQ that is not a power of two never yields an out-of-range ptr.
    always_comb begin
        if (idx_q == IDX_WIDTH'(NUM_REQ - 1)) begin
            ptr_after_owner = '0;
        end else begin
            ptr_after_owner = idx_q + 1'b1;
        end
    end

    // On a done edge the rerun must already use the updated pointer, so the
    // search is fed the post-done value rather than the registered one.
    always_comb begin
        scan_ptr = ptr_q;
        if (state_q == S_GRANT && done) begin
            scan_ptr = ptr_after_owner;
        end
    end

    // Circular priority search starting at scan_ptr; first hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int                   c;
            logic [IDX_WIDTH-1:0] c_idx;
            c = int'(scan_ptr) + i;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            c_idx = IDX_WIDTH'(c);
            if (!win_found && req[c_idx]) begin
                win_found = 1'b1;
                win_idx   = c_idx;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        busy_d  = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    idx_d   = win_idx;
                    busy_d  = 1'b1;
                end
            end
            S_GRANT: begin
                // Grant is frozen until done; req changes are ignored.
                if (done) begin
                    ptr_d = ptr_after_owner;
                    if (win_found) begin
                        gnt_d  = NUM_REQ'(1) << win_idx;
                        idx_d  = win_idx;
                        busy_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign busy    = busy_q;

endmodule
